// File: rtl/mem_sched_pkg.sv
// Shared types for the memory scheduler: FSM states, requester IDs and
// byte-lane geometry of the little-endian word assembly.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;

  typedef logic [LANE_W-1:0] lane_t;

  // Replace byte lane `lane` of `word` with `b` (lane 0 is the low byte).
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input lane_t       lane,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin arbiter; owns the last-served pointer, which only moves
// when the scheduler is idle and actually grants someone.
module mem_rr_arb2
  import mem_sched_pkg::*;
#(
  parameter bit D_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (req[REQ_IF] && req[REQ_D]) begin
      if (last == REQ_D) gnt[REQ_IF] = 1'b1;
      else               gnt[REQ_D]  = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // Pointer starts as if the other side was served last, so the first tie
  // goes to the D_FIRST-selected requester.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last <= D_FIRST ? REQ_IF : REQ_D;
    end else if (en) begin
      if (gnt[REQ_D])       last <= REQ_D;
      else if (gnt[REQ_IF]) last <= REQ_IF;
    end
  end

endmodule

// File: rtl/mem_sched.sv
// Shares a byte-wide memory between instruction fetch and data access:
// word reads as four little-endian byte beats, plus single-byte reads/writes.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit D_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_adr,
  output logic [31:0]      if_rdata,
  output logic             if_done,
  input  logic             d_req,
  input  logic             d_we,
  input  logic             d_word,
  input  logic [WIDTH-1:0] d_adr,
  input  logic [7:0]       d_wdata,
  output logic [31:0]      d_rdata,
  output logic             d_done,
  output logic             busy,
  output logic [WIDTH-1:0] mem_adr,
  output logic [7:0]       mem_writedata,
  output logic             mem_memwrite,
  input  logic [7:0]       mem_memdata
);

  state_t                  state;
  req_id_t                 owner_q;
  logic                    we_q;
  logic                    word_q;
  logic [WIDTH-LANE_W-1:0] word_adr_q;
  lane_t                   cnt;
  logic [31:0]             asm_q;

  logic [1:0]              req_vec;
  logic [1:0]              gnt;
  logic                    arb_en;

  req_id_t                 g_owner;
  logic                    g_we;
  logic                    g_word;
  logic [WIDTH-1:0]        g_adr;
  logic [WIDTH-1:0]        g_first;

  lane_t                   cnt_nxt;
  logic                    last_beat;
  logic [31:0]             rd_result;

  assign req_vec = {d_req, if_req};
  assign arb_en  = (state == IDLE);

  mem_rr_arb2 #(.D_FIRST(D_FIRST)) u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (req_vec),
    .gnt   (gnt)
  );

  // Fields of whichever requester the arbiter picks this cycle.
  always_comb begin
    g_owner = REQ_IF;
    g_we    = 1'b0;
    g_word  = 1'b1;
    g_adr   = if_adr;
    if (gnt[REQ_D]) begin
      g_owner = REQ_D;
      g_we    = d_we;
      g_word  = ~d_we & d_word;
      g_adr   = d_adr;
    end
    g_first = g_word ? {g_adr[WIDTH-1:LANE_W], {LANE_W{1'b0}}} : g_adr;
  end

  always_comb begin
    cnt_nxt   = cnt + lane_t'(1);
    last_beat = !word_q || (cnt == lane_t'(BYTES_PER_WORD - 1));
    rd_result = word_q ? put_lane(asm_q, cnt, mem_memdata)
                       : {24'h0, mem_memdata};
  end

  // NOTE: the assembly register has no reset; every lane is rewritten during
  // a word read before it is ever copied out, so its reset value is dead.
  always_ff @(posedge clk) begin
    if (state == XFER && !we_q) asm_q <= put_lane(asm_q, cnt, mem_memdata);
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // right-hand side sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      owner_q       <= REQ_IF;
      we_q          <= 1'b0;
      word_q        <= 1'b0;
      word_adr_q    <= '0;
      cnt           <= '0;
      if_rdata      <= '0;
      if_done       <= 1'b0;
      d_rdata       <= '0;
      d_done        <= 1'b0;
      busy          <= 1'b0;
      mem_adr       <= '0;
      mem_writedata <= '0;
      mem_memwrite  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner_q      <= g_owner;
            we_q         <= g_we;
            word_q       <= g_word;
            word_adr_q   <= g_adr[WIDTH-1:LANE_W];
            cnt          <= '0;
            mem_adr      <= g_first;
            mem_memwrite <= g_we;
            if (g_we) mem_writedata <= d_wdata;
            busy         <= 1'b1;
            state        <= XFER;
          end
        end

        XFER: begin
          if (last_beat) begin
            mem_memwrite <= 1'b0;
            state        <= DONE;
            if (owner_q == REQ_D) begin
              d_done <= 1'b1;
              if (!we_q) d_rdata <= rd_result;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= rd_result;
            end
          end else begin
            // Lane bits step within the latched word; no carry into the next word.
            cnt     <= cnt_nxt;
            mem_adr <= {word_adr_q, cnt_nxt};
          end
        end

        DONE: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sched.sv
// Self-checking bench for mem_sched: directed vector table, arbitration and
// reset sequences, then random transactions against a byte-array memory model.
module tb_mem_sched;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [7:0]  if_adr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic        d_word;
  logic [7:0]  d_adr;
  logic [7:0]  d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        busy;
  logic [7:0]  mem_adr;
  logic [7:0]  mem_writedata;
  logic        mem_memwrite;
  logic [7:0]  mem_memdata;

  mem_sched #(.WIDTH(8), .D_FIRST(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_req        (if_req),
    .if_adr        (if_adr),
    .if_rdata      (if_rdata),
    .if_done       (if_done),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_word        (d_word),
    .d_adr         (d_adr),
    .d_wdata       (d_wdata),
    .d_rdata       (d_rdata),
    .d_done        (d_done),
    .busy          (busy),
    .mem_adr       (mem_adr),
    .mem_writedata (mem_writedata),
    .mem_memwrite  (mem_memwrite),
    .mem_memdata   (mem_memdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory seen by the DUT, and the bench's expectation of it.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  assign mem_memdata = mem[mem_adr];
  always @(posedge clk) if (mem_memwrite === 1'b1) mem[mem_adr] <= mem_writedata;

  int wr_total = 0;
  always @(negedge clk) if (mem_memwrite === 1'b1) wr_total++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input bit word, input logic [7:0] adr);
    logic [7:0] b;
    b = {adr[7:2], 2'b00};
    if (word) return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    return {24'h0, ref_mem[adr]};
  endfunction

  // Issue one transaction from a negedge in IDLE, follow it to completion and
  // leave the bench at the negedge of the following IDLE cycle.
  task automatic run_txn(input bit is_d, input bit we, input bit word,
                         input logic [7:0] adr, input logic [7:0] wdata,
                         input logic [31:0] exp, input int lat, input string tag);
    bit          weff, wordeff, got;
    logic [7:0]  base;
    logic [31:0] d_before;
    logic [7:0]  seen_adr[$];
    int          n, wr, busy_bad, other_bad;
    weff    = is_d & we;
    wordeff = is_d ? (!we & word) : 1'b1;
    base    = wordeff ? {adr[7:2], 2'b00} : adr;
    if (is_d) begin
      d_we = we; d_word = word; d_adr = adr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      if_adr = adr; if_req = 1'b1;
    end
    d_before = d_rdata;
    n = 0; got = 1'b0; wr = 0; busy_bad = 0; other_bad = 0;
    @(posedge clk);
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_bad++;
      if ((is_d ? if_done : d_done) !== 1'b0) other_bad++;
      if (mem_memwrite === 1'b1) wr++;
      if ((is_d ? d_done : if_done) === 1'b1) got = 1'b1;
      else seen_adr.push_back(mem_adr);
    end
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, n, lat);
    check({tag, " busy during txn"}, busy_bad, 0);
    check({tag, " other done quiet"}, other_bad, 0);
    check({tag, " write cycles"}, wr, 32'(weff));
    check({tag, " beat count"}, seen_adr.size(), lat - 1);
    foreach (seen_adr[i]) check({tag, " mem_adr"}, seen_adr[i], 32'(base) + i);
    if (weff) begin
      check({tag, " d_rdata held"}, d_rdata, d_before);
      check({tag, " mem byte"}, mem[adr], wdata);
      ref_mem[adr] = wdata;
    end else begin
      check({tag, " rdata"}, is_d ? d_rdata : if_rdata, exp);
    end
    @(negedge clk);
    check({tag, " done cleared"}, {if_done, d_done}, 0);
    check({tag, " idle gap"}, busy, 0);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    bit          word;
    logic [7:0]  adr;
    logic [7:0]  wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          order_exp[4];
    int          who;
    int          wr0;
    int          cnt;
    bit          got2;
    bit          r_is_d, r_we, r_word, r_weff_word;
    logic [7:0]  r_adr, r_wdata;

    for (int i = 0; i < 256; i++) begin
      mem[i]     <= 8'(i);
      ref_mem[i]  = 8'(i);
    end
    mem[8'h10] <= 8'h44; mem[8'h11] <= 8'h33; mem[8'h12] <= 8'h22; mem[8'h13] <= 8'h11;
    mem[8'h20] <= 8'hEF; mem[8'h21] <= 8'hBE; mem[8'h22] <= 8'hAD; mem[8'h23] <= 8'hDE;
    ref_mem[8'h10] = 8'h44; ref_mem[8'h11] = 8'h33; ref_mem[8'h12] = 8'h22; ref_mem[8'h13] = 8'h11;
    ref_mem[8'h20] = 8'hEF; ref_mem[8'h21] = 8'hBE; ref_mem[8'h22] = 8'hAD; ref_mem[8'h23] = 8'hDE;

    //            is_d we  word adr     wdata  expected        lat
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 32'h11223344, 5};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h23, 8'h5A, 32'h00000000, 2};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h23, 8'h00, 32'h0000005A, 2};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h13, 8'h00, 32'h11223344, 5};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h21, 8'h00, 32'h5AADBEEF, 5};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h00, 32'h00000022, 2};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 32'hFFFEFDFC, 5};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h40, 8'h77, 32'h00000000, 2};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 32'h00000077, 2};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 8'h14, 8'h00, 32'h17161514, 5};

    reset = 1'b0;
    if_req = 1'b0; if_adr = '0;
    d_req = 1'b0; d_we = 1'b0; d_word = 1'b0; d_adr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mem_adr", mem_adr, 0);
    check("reset mem_writedata", mem_writedata, 0);
    check("reset mem_memwrite", mem_memwrite, 0);
    check("reset busy", busy, 0);
    check("reset if_done", if_done, 0);
    check("reset d_done", d_done, 0);
    check("reset if_rdata", if_rdata, 0);
    check("reset d_rdata", d_rdata, 0);
    reset = 1'b1;

    // Both requesters held continuously from reset: D first, then alternate.
    order_exp[0] = 1; order_exp[1] = 0; order_exp[2] = 1; order_exp[3] = 0;
    wr0 = wr_total;
    d_we = 1'b0; d_word = 1'b0; d_adr = 8'h05; if_adr = 8'h10;
    d_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      who = -1;
      for (int c = 0; c < 20 && who < 0; c++) begin
        @(negedge clk);
        if (d_done === 1'b1 && if_done === 1'b1) who = 2;
        else if (d_done === 1'b1)                who = 1;
        else if (if_done === 1'b1)               who = 0;
      end
      check($sformatf("arb order %0d", k), who, order_exp[k]);
      if (who == 1) check("arb d_rdata", d_rdata, 32'h00000005);
      else          check("arb if_rdata", if_rdata, 32'h11223344);
      if (k == 3) begin d_req = 1'b0; if_req = 1'b0; end
      @(negedge clk);
      check("arb idle cycle", busy, 0);
      if (k < 3) begin
        @(negedge clk);
        check("arb restart after one idle", busy, 1);
      end
    end
    check("no write during reads", wr_total - wr0, 0);

    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].is_d, vecs[i].we, vecs[i].word, vecs[i].adr, vecs[i].wdata,
              vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // Reset during the second XFER cycle of an IF word read.
    if_adr = 8'h10; if_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("midreset busy", busy, 0);
    check("midreset mem_adr", mem_adr, 0);
    check("midreset memwrite", mem_memwrite, 0);
    check("midreset done", {if_done, d_done}, 0);
    check("midreset if_rdata", if_rdata, 0);
    check("midreset d_rdata", d_rdata, 0);
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_done !== 1'b0 || d_done !== 1'b0 || busy !== 1'b0) cnt++;
    end
    check("midreset stays quiet", cnt, 0);
    run_txn(1'b1, 1'b0, 1'b0, 8'h12, 8'h00, 32'h00000022, 2, "post-reset byte");

    // A lone IF grant moves the pointer, so the next tie goes to D.
    run_txn(1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 32'h11223344, 5, "lone IF");
    d_we = 1'b0; d_word = 1'b0; d_adr = 8'h05; if_adr = 8'h10;
    d_req = 1'b1; if_req = 1'b1;
    who = -1;
    for (int c = 0; c < 20 && who < 0; c++) begin
      @(negedge clk);
      if (d_done === 1'b1 && if_done === 1'b1) who = 2;
      else if (d_done === 1'b1)                who = 1;
      else if (if_done === 1'b1)               who = 0;
    end
    check("tie after lone IF", who, 1);
    d_req = 1'b0;
    got2 = 1'b0;
    for (int c = 0; c < 20 && !got2; c++) begin
      @(negedge clk);
      if (if_done === 1'b1) got2 = 1'b1;
    end
    if_req = 1'b0;
    check("tie IF served second", 32'(got2), 1);
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      r_is_d      = 1'($urandom_range(0, 1));
      r_we        = r_is_d && ($urandom_range(0, 2) == 0);
      r_word      = 1'($urandom_range(0, 1));
      r_adr       = 8'($urandom);
      r_wdata     = 8'($urandom);
      r_weff_word = r_is_d ? (!r_we && r_word) : 1'b1;
      run_txn(r_is_d, r_we, r_word, r_adr, r_wdata, ref_read(r_weff_word, r_adr),
              r_weff_word ? 5 : 2, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
